// File: rtl/execute_mc.sv
// execute_mc: parametrised execute stage of the pipelined ARM core.
// Operand forwarding, WIDTH-bit ALU, NZCV flag register, condition unit and the
// E->M pipeline register. Optional feature macro: MUL_UNIT_EN builds the
// iterative shift-add multiplier (IDLE/MUL FSM) with its BusyE stall request.
module execute_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA    = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             RegWriteE,
  input  logic             MemToRegE,
  input  logic             MemWriteE,
  input  logic             PCSrcE,
  input  logic             BranchE,
  input  logic             FlagWriteE,
  input  logic             ALUSrcE,
  input  logic             MulE,
  input  logic             FlushE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RA-1:0]    WA3E,
  input  logic [3:0]       ALUControlE,
  input  logic [3:0]       CondE,
  output logic             BranchTakenE,
  output logic             BusyE,
  output logic [3:0]       FlagsE,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RA-1:0]    WA3M,
  output logic             RegWriteM,
  output logic             MemToRegM,
  output logic             MemWriteM,
  output logic             PCSrcM
);

  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] src_a, src_b_reg, src_b;
  logic [WIDTH-1:0] alu_res, b_op;
  logic [WIDTH:0]   sum;
  logic             is_sub, arith, res_c, res_v;
  logic [3:0]       alu_flags;
  logic             cond_ex, live;
  logic             fn, fz, fc, fv;

  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] alu_result_m_q, alu_result_m_d;
  logic [WIDTH-1:0] write_data_m_q, write_data_m_d;
  logic [RA-1:0]    wa3_m_q, wa3_m_d;
  logic             reg_write_m_q, reg_write_m_d;
  logic             mem_to_reg_m_q, mem_to_reg_m_d;
  logic             mem_write_m_q, mem_write_m_d;
  logic             pc_src_m_q, pc_src_m_d;

  // Forwarding muxes and immediate select
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   src_b_reg = ResultW;
      2'b10:   src_b_reg = alu_result_m_q;
      default: src_b_reg = RD2E;
    endcase
    src_b = ALUSrcE ? ExtImmE : src_b_reg;
  end

  // ALU: shared adder for ADD/SUB; logic ops and shifts keep the old C and V
  always_comb begin
    is_sub  = (ALUControlE == 4'd1);
    b_op    = is_sub ? ~src_b : src_b;
    sum     = {1'b0, src_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    alu_res = sum[WIDTH-1:0];
    arith   = 1'b1;
    case (ALUControlE)
      4'd2:    begin alu_res = src_a & src_b;            arith = 1'b0; end
      4'd3:    begin alu_res = src_a | src_b;            arith = 1'b0; end
      4'd4:    begin alu_res = src_a ^ src_b;            arith = 1'b0; end
      4'd5:    begin alu_res = src_b;                    arith = 1'b0; end
      4'd6:    begin alu_res = src_a << src_b[SHW-1:0];  arith = 1'b0; end
      4'd7:    begin alu_res = src_a >> src_b[SHW-1:0];  arith = 1'b0; end
      default: ;
    endcase
    res_c = flags_q[1];
    res_v = flags_q[0];
    if (arith) begin
      res_c = sum[WIDTH];
      res_v = (src_a[MSB] == b_op[MSB]) && (sum[MSB] != src_a[MSB]);
    end
    alu_flags = {alu_res[MSB], (alu_res == '0), res_c, res_v};
  end

  // Condition unit evaluated against the architectural flags
  always_comb begin
    {fn, fz, fc, fv} = flags_q;
    case (CondE)
      4'h0:    cond_ex = fz;
      4'h1:    cond_ex = !fz;
      4'h2:    cond_ex = fc;
      4'h3:    cond_ex = !fc;
      4'h4:    cond_ex = fn;
      4'h5:    cond_ex = !fn;
      4'h6:    cond_ex = fv;
      4'h7:    cond_ex = !fv;
      4'h8:    cond_ex = fc && !fz;
      4'h9:    cond_ex = !fc || fz;
      4'hA:    cond_ex = (fn == fv);
      4'hB:    cond_ex = (fn != fv);
      4'hC:    cond_ex = !fz && (fn == fv);
      4'hD:    cond_ex = fz || (fn != fv);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign live         = cond_ex & !FlushE;
  assign BranchTakenE = BranchE & live;

`ifdef MUL_UNIT_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [RA-1:0]    mwa3_q, mwa3_d;
  logic             mrw_q, mrw_d, mmtr_q, mmtr_d, mmw_q, mmw_d, mpc_q, mpc_d, mfw_q, mfw_d;
  logic             mul_start, mul_done, in_mul;

  assign in_mul    = (state_q == S_MUL);
  assign mul_start = (state_q == S_IDLE) & MulE & live;
  assign mul_done  = in_mul & (cnt_q == '0) & !FlushE;
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign BusyE     = !reset & (mul_start | (in_mul & (cnt_q != '0)));

  // Multiplier next state: latch operands/controls on start, one shift-add step per MUL cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mwa3_d   = mwa3_q;
    mrw_d    = mrw_q;
    mmtr_d   = mmtr_q;
    mmw_d    = mmw_q;
    mpc_d    = mpc_q;
    mfw_d    = mfw_q;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          state_d  = S_MUL;
          cnt_d    = CNTW'(WIDTH - 1);
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          mwa3_d   = WA3E;
          mrw_d    = RegWriteE;
          mmtr_d   = MemToRegE;
          mmw_d    = MemWriteE;
          mpc_d    = PCSrcE;
          mfw_d    = FlagWriteE;
        end
      end
      S_MUL: begin
        if (FlushE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
`else
  assign BusyE = 1'b0;
`endif

  // E->M register and flag register next values
  always_comb begin
    alu_result_m_d = alu_res;
    write_data_m_d = src_b_reg;
    wa3_m_d        = WA3E;
    reg_write_m_d  = RegWriteE & live;
    mem_to_reg_m_d = MemToRegE;
    mem_write_m_d  = MemWriteE & live;
    pc_src_m_d     = PCSrcE & live;
    flags_d        = flags_q;
    if (FlagWriteE & live) flags_d = alu_flags;
`ifdef MUL_UNIT_EN
    if (mul_done) begin
      alu_result_m_d = acc_step;
      wa3_m_d        = mwa3_q;
      reg_write_m_d  = mrw_q;
      mem_to_reg_m_d = mmtr_q;
      mem_write_m_d  = mmw_q;
      pc_src_m_d     = mpc_q;
      flags_d        = flags_q;
      if (mfw_q) flags_d[3:2] = {acc_step[MSB], (acc_step == '0)};
    end else if (mul_start | in_mul) begin
      wa3_m_d        = '0;
      reg_write_m_d  = 1'b0;
      mem_to_reg_m_d = 1'b0;
      mem_write_m_d  = 1'b0;
      pc_src_m_d     = 1'b0;
      flags_d        = flags_q;
    end
`else
    if (MulE) begin
      wa3_m_d        = '0;
      reg_write_m_d  = 1'b0;
      mem_to_reg_m_d = 1'b0;
      mem_write_m_d  = 1'b0;
      pc_src_m_d     = 1'b0;
      flags_d        = flags_q;
    end
`endif
  end

  // State registers, asynchronously cleared
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      flags_q        <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      wa3_m_q        <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      pc_src_m_q     <= 1'b0;
`ifdef MUL_UNIT_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mwa3_q   <= '0;
      mrw_q    <= 1'b0;
      mmtr_q   <= 1'b0;
      mmw_q    <= 1'b0;
      mpc_q    <= 1'b0;
      mfw_q    <= 1'b0;
`endif
    end else begin
      flags_q        <= flags_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      wa3_m_q        <= wa3_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_write_m_q  <= mem_write_m_d;
      pc_src_m_q     <= pc_src_m_d;
`ifdef MUL_UNIT_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mwa3_q   <= mwa3_d;
      mrw_q    <= mrw_d;
      mmtr_q   <= mmtr_d;
      mmw_q    <= mmw_d;
      mpc_q    <= mpc_d;
      mfw_q    <= mfw_d;
`endif
    end
  end

  assign FlagsE     = flags_q;
  assign ALUResultM = alu_result_m_q;
  assign WriteDataM = write_data_m_q;
  assign WA3M       = wa3_m_q;
  assign RegWriteM  = reg_write_m_q;
  assign MemToRegM  = mem_to_reg_m_q;
  assign MemWriteM  = mem_write_m_q;
  assign PCSrcM     = pc_src_m_q;

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc (WIDTH=32): table of ALU vectors, directed forwarding and
// multiplier sequences, then randomized instructions against a reference model.
module tb_execute_mc;

  localparam int unsigned W  = 32;
  localparam int unsigned RA = 4;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic          Clk = 1'b0;
  logic          reset;
  logic          RegWriteE, MemToRegE, MemWriteE, PCSrcE, BranchE, FlagWriteE, ALUSrcE, MulE, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [W-1:0]  RD1E, RD2E, ExtImmE, ResultW;
  logic [RA-1:0] WA3E;
  logic [3:0]    ALUControlE, CondE;
  logic          BranchTakenE, BusyE;
  logic [3:0]    FlagsE;
  logic [W-1:0]  ALUResultM, WriteDataM;
  logic [RA-1:0] WA3M;
  logic          RegWriteM, MemToRegM, MemWriteM, PCSrcM;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0]      mf;
  longint unsigned malu;
  bit              mvalid;

  execute_mc #(.WIDTH(W), .RA(RA)) dut (
    .Clk(Clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .BranchE(BranchE), .FlagWriteE(FlagWriteE), .ALUSrcE(ALUSrcE), .MulE(MulE), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW),
    .WA3E(WA3E), .ALUControlE(ALUControlE), .CondE(CondE),
    .BranchTakenE(BranchTakenE), .BusyE(BusyE), .FlagsE(FlagsE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_defaults();
    RegWriteE = 0; MemToRegE = 0; MemWriteE = 0; PCSrcE = 0; BranchE = 0;
    FlagWriteE = 0; ALUSrcE = 0; MulE = 0; FlushE = 0;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1E = '0; RD2E = '0; ExtImmE = '0; ResultW = '0;
    WA3E = '0; ALUControlE = 4'd0; CondE = 4'hE;
  endtask

  // ARM condition table
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sgn(input longint unsigned x);
    return (x >= 64'h8000_0000) ? longint'(x) - 64'sh1_0000_0000 : longint'(x);
  endfunction

  function automatic longint unsigned fwd(input logic [1:0] sel, input logic [W-1:0] rd);
    case (sel)
      2'b01:   return longint'(ResultW);
      2'b10:   return malu;
      default: return longint'(rd);
    endcase
  endfunction

  // ALU reference using wide integer arithmetic
  task automatic alu_model(input logic [3:0] ctl, input longint unsigned a, input longint unsigned b,
                           input logic [3:0] fin, output longint unsigned res, output logic [3:0] fout);
    longint s;
    logic c, v;
    c = fin[1];
    v = fin[0];
    case (ctl)
      4'd1: begin
        res = (a - b) & MASK; c = (a >= b); s = sgn(a) - sgn(b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = b;
      4'd6: res = (a << (b % 32)) & MASK;
      4'd7: res = a >> (b % 32);
      default: begin
        res = (a + b) & MASK; c = (a + b) > MASK; s = sgn(a) + sgn(b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    fout = {res[31], res == 0, c, v};
  endtask

`ifdef MUL_UNIT_EN
  // Multiplier occupancy: hold the instruction in E while BusyE, scramble data inputs
  task automatic run_mul(input string tag, input longint unsigned a, input longint unsigned b);
    logic rw, mtr, mw, pc, fw;
    logic [RA-1:0] wa;
    longint unsigned p;
    int busy_cnt;
    rw = RegWriteE; mtr = MemToRegE; mw = MemWriteE; pc = PCSrcE; fw = FlagWriteE; wa = WA3E;
    p = (a * b) & MASK;
    busy_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk({tag, "_mul_bubble_rw"}, RegWriteM, 0);
      chk({tag, "_mul_bubble_mw"}, MemWriteM, 0);
      chk({tag, "_mul_flags_hold"}, FlagsE, mf);
      RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ExtImmE = $urandom;
      #1;
      if (!BusyE) break;
      busy_cnt++;
    end
    chk({tag, "_busy_cycles"}, busy_cnt, W);
    tick();
    chk({tag, "_product"}, ALUResultM, p);
    chk({tag, "_rw"}, RegWriteM, rw);
    chk({tag, "_mtr"}, MemToRegM, mtr);
    chk({tag, "_mw"}, MemWriteM, mw);
    chk({tag, "_pc"}, PCSrcM, pc);
    chk({tag, "_wa3"}, WA3M, wa);
    if (fw) mf[3:2] = {p[31], p == 0};
    chk({tag, "_flags"}, FlagsE, mf);
    malu = p;
    mvalid = 1;
  endtask
`endif

  // Apply the instruction currently on the inputs and check it against the model
  task automatic exec_and_check(input string tag);
    logic ok, bub;
    longint unsigned a, bi, b, res;
    logic [3:0] nf;
    #1;
    ok = cond_ok(CondE, mf);
    a  = fwd(ForwardAE, RD1E);
    bi = fwd(ForwardBE, RD2E);
    b  = ALUSrcE ? longint'(ExtImmE) : bi;
    chk({tag, "_branch_taken"}, BranchTakenE, BranchE & ok & !FlushE);
`ifdef MUL_UNIT_EN
    chk({tag, "_busy"}, BusyE, MulE & ok & !FlushE);
    if (MulE && ok && !FlushE) begin
      run_mul(tag, a, b);
      return;
    end
    bub = 1'b0;
`else
    chk({tag, "_busy"}, BusyE, 0);
    bub = MulE;
`endif
    alu_model(ALUControlE, a, b, mf, res, nf);
    tick();
    if (bub) begin
      chk({tag, "_bubble_rw"}, RegWriteM, 0);
      chk({tag, "_bubble_mtr"}, MemToRegM, 0);
      chk({tag, "_bubble_mw"}, MemWriteM, 0);
      chk({tag, "_bubble_pc"}, PCSrcM, 0);
      mvalid = 0;
    end else begin
      chk({tag, "_rw"}, RegWriteM, RegWriteE & ok & !FlushE);
      chk({tag, "_mw"}, MemWriteM, MemWriteE & ok & !FlushE);
      chk({tag, "_pc"}, PCSrcM, PCSrcE & ok & !FlushE);
      chk({tag, "_mtr"}, MemToRegM, MemToRegE);
      chk({tag, "_wa3"}, WA3M, WA3E);
      if (!FlushE && !MulE) begin
        chk({tag, "_result"}, ALUResultM, res);
        chk({tag, "_wdata"}, WriteDataM, bi);
        malu = res;
        mvalid = 1;
      end else begin
        mvalid = 0;
      end
      if (FlagWriteE && ok && !FlushE) mf = nf;
    end
    chk({tag, "_flags"}, FlagsE, mf);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    @(posedge Clk);
    #2;
    reset = 1'b0;
    #1;
    mf = 4'b0000;
    malu = 0;
    mvalid = 1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a, b;
    logic         fw;
    logic [3:0]   cond;
    logic         rw, br;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         rw_m, bt;
  } vec_t;

  vec_t vt[16];

  initial begin
    // ctl, a, b, fw, cond, rw, br, res, flags(NZCV), RegWriteM, BranchTakenE
    vt[0]  = '{4'd0, 32'd7,         32'd5,         1'b1, 4'hE, 1'b1, 1'b0, 32'd12,        4'b0000, 1'b1, 1'b0};
    vt[1]  = '{4'd1, 32'd5,         32'd5,         1'b1, 4'hE, 1'b1, 1'b0, 32'd0,         4'b0110, 1'b1, 1'b0};
    vt[2]  = '{4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 4'hE, 1'b1, 1'b0, 32'h0000_00F0, 4'b0010, 1'b1, 1'b0};
    vt[3]  = '{4'd3, 32'h8000_0000, 32'd1,         1'b1, 4'hE, 1'b1, 1'b0, 32'h8000_0001, 4'b1010, 1'b1, 1'b0};
    vt[4]  = '{4'd4, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 4'hE, 1'b1, 1'b0, 32'd0,         4'b0110, 1'b1, 1'b0};
    vt[5]  = '{4'd0, 32'h7FFF_FFFF, 32'd1,         1'b1, 4'hE, 1'b1, 1'b0, 32'h8000_0000, 4'b1001, 1'b1, 1'b0};
    vt[6]  = '{4'd1, 32'd3,         32'd5,         1'b1, 4'hE, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b1, 1'b0};
    vt[7]  = '{4'd0, 32'hFFFF_FFFF, 32'd1,         1'b1, 4'hE, 1'b1, 1'b0, 32'd0,         4'b0110, 1'b1, 1'b0};
    vt[8]  = '{4'd5, 32'd99,        32'h0000_1234, 1'b0, 4'hE, 1'b1, 1'b0, 32'h0000_1234, 4'b0110, 1'b1, 1'b0};
    vt[9]  = '{4'd6, 32'd1,         32'd31,        1'b1, 4'hE, 1'b1, 1'b0, 32'h8000_0000, 4'b1010, 1'b1, 1'b0};
    vt[10] = '{4'd7, 32'h8000_0000, 32'h0000_0024, 1'b1, 4'hE, 1'b1, 1'b0, 32'h0800_0000, 4'b0010, 1'b1, 1'b0};
    vt[11] = '{4'd9, 32'd2,         32'd3,         1'b1, 4'hE, 1'b1, 1'b0, 32'd5,         4'b0000, 1'b1, 1'b0};
    vt[12] = '{4'd1, 32'h8000_0000, 32'd1,         1'b1, 4'hE, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b1, 1'b0};
    vt[13] = '{4'd1, 32'd9,         32'd9,         1'b1, 4'hE, 1'b1, 1'b0, 32'd0,         4'b0110, 1'b1, 1'b0};
    vt[14] = '{4'd0, 32'd1,         32'd1,         1'b1, 4'h1, 1'b1, 1'b1, 32'd2,         4'b0110, 1'b0, 1'b0};
    vt[15] = '{4'd0, 32'd1,         32'd1,         1'b0, 4'h0, 1'b1, 1'b1, 32'd2,         4'b0110, 1'b1, 1'b1};

    // reset state, with MulE high to confirm BusyE stays low in reset
    set_defaults();
    reset = 1'b1;
    MulE = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", BusyE, 0);
    chk("rst_flags", FlagsE, 0);
    chk("rst_alu", ALUResultM, 0);
    chk("rst_wdata", WriteDataM, 0);
    chk("rst_wa3", WA3M, 0);
    chk("rst_ctrl", {RegWriteM, MemToRegM, MemWriteM, PCSrcM}, 0);
    MulE = 1'b0;
    #1;
    reset = 1'b0;
    mf = 4'b0000; malu = 0; mvalid = 1;

    // table-driven ALU vectors
    for (int i = 0; i < 16; i++) begin
      set_defaults();
      ALUControlE = vt[i].ctl; RD1E = vt[i].a; RD2E = vt[i].b; FlagWriteE = vt[i].fw;
      CondE = vt[i].cond; RegWriteE = vt[i].rw; BranchE = vt[i].br; WA3E = RA'(i);
      #1;
      chk($sformatf("vec%0d_branch_taken", i), BranchTakenE, vt[i].bt);
      tick();
      chk($sformatf("vec%0d_result", i), ALUResultM, vt[i].res);
      chk($sformatf("vec%0d_flags", i), FlagsE, vt[i].flags);
      chk($sformatf("vec%0d_regwrite", i), RegWriteM, vt[i].rw_m);
    end

    // forwarding sequences
    set_defaults(); RD1E = 7; RD2E = 5; RegWriteE = 1;
    tick();
    chk("fwd_base", ALUResultM, 12);
    set_defaults(); ForwardAE = 2'b10; RD1E = 999; ALUSrcE = 1; ExtImmE = 3;
    tick();
    chk("fwd_a_from_m", ALUResultM, 15);
    set_defaults(); ForwardBE = 2'b01; ResultW = 9; RD2E = 77; MemWriteE = 1; ALUSrcE = 1; ExtImmE = 4;
    tick();
    chk("fwd_b_store_data", WriteDataM, 9);
    chk("fwd_b_memwrite", MemWriteM, 1);
    chk("fwd_flags_hold", FlagsE, 4'b0110);

`ifdef MUL_UNIT_EN
    do_reset();
    set_defaults(); RD1E = 6; RD2E = 7; MulE = 1; RegWriteE = 1; WA3E = 4'd3;
    exec_and_check("mul6x7");
    chk("mul6x7_value", ALUResultM, 42);
    set_defaults(); RD1E = 32'hFFFF_FFFF; RD2E = 2; MulE = 1; RegWriteE = 1; FlagWriteE = 1;
    exec_and_check("mulmax");
    chk("mulmax_value", ALUResultM, 32'hFFFF_FFFE);

    // flush in MUL cycle 10
    set_defaults(); RD1E = 6; RD2E = 7; MulE = 1; RegWriteE = 1; FlagWriteE = 1;
    #1;
    chk("flush_start_busy", BusyE, 1);
    repeat (10) tick();
    chk("flush_pre_busy", BusyE, 1);
    FlushE = 1;
    tick();
    FlushE = 0; MulE = 0;
    #1;
    chk("flush_busy_drop", BusyE, 0);
    chk("flush_bubble_rw", RegWriteM, 0);
    chk("flush_flags", FlagsE, mf);
    mvalid = 0;
    set_defaults(); RD1E = 20; RD2E = 22; RegWriteE = 1;
    exec_and_check("after_flush");

    // asynchronous reset in the middle of a MUL
    set_defaults(); RD1E = 3; RD2E = 5; ALUControlE = 4'd1; FlagWriteE = 1; RegWriteE = 1;
    exec_and_check("pre_rst_sub");
    set_defaults(); RD1E = 6; RD2E = 7; MulE = 1; RegWriteE = 1;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midmul_rst_busy", BusyE, 0);
    chk("midmul_rst_flags", FlagsE, 0);
    chk("midmul_rst_alu", ALUResultM, 0);
    chk("midmul_rst_ctrl", {RegWriteM, MemToRegM, MemWriteM, PCSrcM}, 0);
    MulE = 0;
`else
    // MulE without the multiplier: bubble, no flag write, no stall
    set_defaults(); MulE = 1; RegWriteE = 1; MemToRegE = 1; MemWriteE = 1; PCSrcE = 1;
    FlagWriteE = 1; RD1E = 32'h7FFF_FFFF; RD2E = 1;
    #1;
    chk("mule_busy", BusyE, 0);
    tick();
    chk("mule_bubble_ctrl", {RegWriteM, MemToRegM, MemWriteM, PCSrcM}, 0);
    chk("mule_flags_hold", FlagsE, 4'b0110);
    MulE = 0;
    tick();
    chk("add_ovf_result", ALUResultM, 32'h8000_0000);
    chk("add_ovf_flags", FlagsE, 4'b1001);
`endif

    // randomized instructions against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      ALUControlE = 4'($urandom_range(0, 15));
      RD1E = rnd_word(); RD2E = rnd_word(); ExtImmE = rnd_word(); ResultW = rnd_word();
      ForwardAE = 2'($urandom_range(0, 3));
      ForwardBE = 2'($urandom_range(0, 3));
      if (!mvalid && ForwardAE == 2'b10) ForwardAE = 2'b00;
      if (!mvalid && ForwardBE == 2'b10) ForwardBE = 2'b00;
      ALUSrcE = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      MemToRegE = 1'($urandom_range(0, 1));
      MemWriteE = 1'($urandom_range(0, 1));
      PCSrcE = 1'($urandom_range(0, 1));
      BranchE = 1'($urandom_range(0, 1));
      FlagWriteE = 1'($urandom_range(0, 1));
      CondE = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      FlushE = ($urandom_range(0, 9) == 0);
      MulE = ($urandom_range(0, 5) == 0);
      WA3E = RA'($urandom_range(0, 15));
      exec_and_check("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
